// File: rtl/regfile_scoreboard.sv
// ============================================================================
//  Module      : regfile_scoreboard
//  Description : Two-read/one-write integer register file with a per-register
//                busy scoreboard and a sequential index-loading init walk.
//                Optional write-first forwarding: define REGFILE_BYPASS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_scoreboard #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ra_addr,
    output logic [DATA_W-1:0] ra_data,
    output logic              ra_busy,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0] rb_data,
    output logic              rb_busy,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_rd,
    output logic              ready
);

    localparam int NREGS = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] c_last_idx = '1;
    localparam logic [ADDR_W-1:0] c_zero_idx = '0;

    localparam logic [0:0] S_INIT = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_init_cnt;
    logic [NREGS-1:0]  r_busy;
    logic              r_ready;
    logic [DATA_W-1:0] r_mem [NREGS];

    logic [DATA_W-1:0] w_init_data;
    logic              w_run;
    logic              w_wr_ok;
    logic              w_issue_ok;

    assign w_run      = (r_state == S_RUN);
    assign w_wr_ok    = w_run && wr_en && (wr_addr != c_zero_idx);
    assign w_issue_ok = w_run && issue_en && (issue_rd != c_zero_idx);

    // Walk value is the entry index, zero-extended or truncated to DATA_W.
    generate
        if (DATA_W > ADDR_W) begin : g_init_zext
            assign w_init_data = {{(DATA_W-ADDR_W){1'b0}}, r_init_cnt};
        end else if (DATA_W == ADDR_W) begin : g_init_same
            assign w_init_data = r_init_cnt;
        end else begin : g_init_trunc
            assign w_init_data = r_init_cnt[DATA_W-1:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_INIT;
            r_init_cnt <= '0;
            r_busy     <= '0;
            r_ready    <= 1'b0;
        end else begin
            case (r_state)
                S_INIT: begin
                    if (r_init_cnt == c_last_idx) begin
                        r_state <= S_RUN;
                        r_ready <= 1'b1;
                    end else begin
                        r_init_cnt <= r_init_cnt + 1'b1;
                    end
                end
                default: begin
                    // Clear first so a same-cycle issue (newer producer) wins.
                    if (wr_en) begin
                        r_busy[wr_addr] <= 1'b0;
                    end
                    if (w_issue_ok) begin
                        r_busy[issue_rd] <= 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_state == S_INIT) begin
                r_mem[r_init_cnt] <= w_init_data;
            end else if (w_wr_ok) begin
                r_mem[wr_addr] <= wr_data;
            end
        end
    end

    logic w_fwd_a;
    logic w_fwd_b;

`ifdef REGFILE_BYPASS_EN
    assign w_fwd_a = w_wr_ok && (wr_addr == ra_addr);
    assign w_fwd_b = w_wr_ok && (wr_addr == rb_addr);
`else
    assign w_fwd_a = 1'b0;
    assign w_fwd_b = 1'b0;
`endif

    always_comb begin
        ra_data = '0;
        ra_busy = 1'b0;
        if (ra_addr != c_zero_idx) begin
            ra_data = w_fwd_a ? wr_data : r_mem[ra_addr];
            ra_busy = w_fwd_a ? 1'b0    : r_busy[ra_addr];
        end
    end

    always_comb begin
        rb_data = '0;
        rb_busy = 1'b0;
        if (rb_addr != c_zero_idx) begin
            rb_data = w_fwd_b ? wr_data : r_mem[rb_addr];
            rb_busy = w_fwd_b ? 1'b0    : r_busy[rb_addr];
        end
    end

    assign ready = r_ready;

endmodule

`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
// ============================================================================
//  Module      : tb_regfile_scoreboard
//  Description : Directed self-checking bench for regfile_scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  ra_addr, rb_addr, wr_addr, issue_rd;
    logic [31:0] ra_data, rb_data, wr_data;
    logic        ra_busy, rb_busy, wr_en, issue_en, ready;

    int n_checks = 0;
    int n_errors = 0;

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .ra_addr  (ra_addr),
        .ra_data  (ra_data),
        .ra_busy  (ra_busy),
        .rb_addr  (rb_addr),
        .rb_data  (rb_data),
        .rb_busy  (rb_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .issue_en (issue_en),
        .issue_rd (issue_rd),
        .ready    (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Walks the init sequence checking ready is low on edges 1..31, high on 32.
    task automatic walk_init(input string tag);
        for (int e = 1; e <= 32; e++) begin
            tick();
            check($sformatf("%s_ready_e%0d", tag, e), {31'd0, ready}, (e == 32) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; issue_en = 1'b0;
        ra_addr = '0; rb_addr = '0; wr_addr = '0; issue_rd = '0; wr_data = '0;
        tick();
        tick();
        ra_addr = 5'd5;
        check("reset_ready", {31'd0, ready}, 32'd0);
        check("reset_busy5", {31'd0, ra_busy}, 32'd0);
        reset = 1'b0;

        // Init walk with write/issue to r4 attempted mid-walk (after r4 walked).
        for (int e = 1; e <= 32; e++) begin
            tick();
            check($sformatf("init_ready_e%0d", e), {31'd0, ready}, (e == 32) ? 32'd1 : 32'd0);
            if (e == 5) begin
                wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'hAAAA_AAAA;
                issue_en = 1'b1; issue_rd = 5'd4;
            end else if (e == 9) begin
                wr_en = 1'b0; issue_en = 1'b0;
            end
        end

        ra_addr = 5'd7; rb_addr = 5'd31; #1;
        check("rd_r7", ra_data, 32'd7);
        check("rd_r31", rb_data, 32'd31);
        ra_addr = 5'd0; #1;
        check("rd_r0", ra_data, 32'd0);
        ra_addr = 5'd4; #1;
        check("init_ignored_r4_data", ra_data, 32'd4);
        check("init_ignored_r4_busy", {31'd0, ra_busy}, 32'd0);

        // Issue r5, then write back r5.
        ra_addr = 5'd5; issue_en = 1'b1; issue_rd = 5'd5; #1;
        check("issue5_same_cycle_busy", {31'd0, ra_busy}, 32'd0);
        tick();
        issue_en = 1'b0; #1;
        check("issue5_busy", {31'd0, ra_busy}, 32'd1);
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF; #1;
`ifdef REGFILE_BYPASS_EN
        check("wr5_same_data", ra_data, 32'hDEAD_BEEF);
        check("wr5_same_busy", {31'd0, ra_busy}, 32'd0);
`else
        check("wr5_same_data", ra_data, 32'd5);
        check("wr5_same_busy", {31'd0, ra_busy}, 32'd1);
`endif
        tick();
        wr_en = 1'b0; #1;
        check("wr5_data", ra_data, 32'hDEAD_BEEF);
        check("wr5_busy", {31'd0, ra_busy}, 32'd0);

        // Simultaneous issue and write to r9: busy ends set, data written.
        ra_addr = 5'd9; rb_addr = 5'd9;
        issue_en = 1'b1; issue_rd = 5'd9;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h55;
        tick();
        issue_en = 1'b0; wr_en = 1'b0; #1;
        check("r9_busy_a", {31'd0, ra_busy}, 32'd1);
        check("r9_busy_b", {31'd0, rb_busy}, 32'd1);
        check("r9_data", ra_data, 32'h55);

        // Register 0 ignores writes and issues.
        ra_addr = 5'd0;
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
        issue_en = 1'b1; issue_rd = 5'd0;
        tick();
        wr_en = 1'b0; issue_en = 1'b0; #1;
        check("r0_data", ra_data, 32'd0);
        check("r0_busy", {31'd0, ra_busy}, 32'd0);

        // Write r3 and mark r6 busy, then reset in RUN.
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h1234;
        issue_en = 1'b1; issue_rd = 5'd6;
        tick();
        wr_en = 1'b0; issue_en = 1'b0;
        ra_addr = 5'd3; rb_addr = 5'd6; #1;
        check("r3_written", ra_data, 32'h1234);
        check("r6_busy", {31'd0, rb_busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0; #1;
        check("run_reset_ready", {31'd0, ready}, 32'd0);
        check("run_reset_busy6", {31'd0, rb_busy}, 32'd0);

        // Abort the walk at init_cnt=10, then walk fully.
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; #1;
        check("init_reset_ready", {31'd0, ready}, 32'd0);
        walk_init("rewalk");
        #1;
        check("r3_rewalk", ra_data, 32'd3);
        check("r6_rewalk_busy", {31'd0, rb_busy}, 32'd0);
        check("r6_rewalk_data", rb_data, 32'd6);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
